// File: rtl/bus_slave_timer_pkg.sv
// Shared definitions for the bus slave timer: register offsets, CTRL bit
// layout, bus-slave FSM state encodings and a wait-state helper.
package bus_slave_timer_pkg;

   // Register offsets decoded from bus_addr[1:0]
   localparam logic [1:0] OFF_CTRL    = 2'd0;
   localparam logic [1:0] OFF_INTR    = 2'd1;
   localparam logic [1:0] OFF_EXPR    = 2'd2;
   localparam logic [1:0] OFF_COUNTER = 2'd3;

   // CTRL bit positions
   localparam int CTRL_START_BIT    = 0;
   localparam int CTRL_PERIODIC_BIT = 1;

   // Bus slave FSM state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

   // Largest supported number of wait states (fits the 4-bit wait counter)
   localparam int WAIT_MAX = 15;

   // CTRL register image; packed so bit 0 is start and bit 1 is periodic
   typedef struct packed {
      logic periodic;
      logic start;
   } ctrl_t;

   // Value loaded into the wait-state down-counter at strobe capture.
   // With zero wait states the counter is never consulted, so 0 is loaded.
   function automatic logic [3:0] wait_load(input int wait_cyc);
      logic [3:0] load_v;
      if (wait_cyc <= 0) begin
         load_v = 4'd0;
      end else if (wait_cyc > WAIT_MAX) begin
         load_v = 4'(WAIT_MAX - 1);
      end else begin
         load_v = 4'(wait_cyc - 1);
      end
      return load_v;
   endfunction

endpackage

// File: rtl/bus_slave_ctrl.sv
// Generic req/grnt/as/rdy bus responder front end. Captures a strobed
// access, inserts WAIT_CYC wait states and then presents a one-cycle
// register read or write strobe together with the captured offset and
// write data. bus_rdy is high for exactly the cycle of that strobe.
// Reusable by other slaves (UART, GPIO) that sit behind the same bus.
module bus_slave_ctrl
   import bus_slave_timer_pkg::*;
#(
   parameter int WAIT_CYC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        bus_as,
   input  logic        bus_rw,
   input  logic [1:0]  bus_off,
   input  logic [31:0] bus_wr_data,
   output logic        bus_rdy,
   output logic        reg_we,
   output logic        reg_re,
   output logic [1:0]  reg_off,
   output logic [31:0] reg_wdata
);

   localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYC);

   logic [1:0]  state_r;
   logic [1:0]  state_nxt_s;
   logic        capture_s;
   logic [3:0]  wait_cnt_r;
   logic        rw_r;
   logic [1:0]  off_r;
   logic [31:0] wdata_r;

   // Next-state decode; strobes outside IDLE are dropped (no queueing)
   always_comb begin
      state_nxt_s = state_r;
      capture_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cs && bus_as) begin
               capture_s   = 1'b1;
               state_nxt_s = (WAIT_CYC == 0) ? ST_READY : ST_WAIT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_r == 4'd0) begin
               state_nxt_s = ST_READY;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_READY: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register; reset abandons any access in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Wait-state down-counter: loaded at capture, counts down while waiting
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_r <= 4'd0;
      end else if (capture_s) begin
         wait_cnt_r <= WAIT_LOAD;
      end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
         wait_cnt_r <= wait_cnt_r - 4'd1;
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // Capture latches for direction, offset and write data
   always_ff @(posedge clk) begin
      if (rst) begin
         rw_r    <= 1'b0;
         off_r   <= 2'd0;
         wdata_r <= 32'd0;
      end else if (capture_s) begin
         rw_r    <= bus_rw;
         off_r   <= bus_off;
         wdata_r <= bus_wr_data;
      end else begin
         rw_r    <= rw_r;
         off_r   <= off_r;
         wdata_r <= wdata_r;
      end
   end

   assign bus_rdy   = (state_r == ST_READY);
   assign reg_we    = bus_rdy & rw_r;
   assign reg_re    = bus_rdy & ~rw_r;
   assign reg_off   = off_r;
   assign reg_wdata = wdata_r;

endmodule

// File: rtl/bus_slave_timer.sv
// Interval timer behind the system bus. Four registers (CTRL, INTR, EXPR,
// COUNTER) are reached through bus_slave_ctrl. While CTRL.start is set the
// counter advances every cycle; on reaching EXPR it wraps to 0, raises
// INTR[0] and, unless periodic, clears start. irq mirrors INTR[0].
module bus_slave_timer
   import bus_slave_timer_pkg::*;
#(
   parameter int WAIT_CYC = 1,
   parameter int CNT_W    = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        bus_as,
   input  logic        bus_rw,
   input  logic [29:0] bus_addr,
   input  logic [31:0] bus_wr_data,
   output logic [31:0] bus_rd_data,
   output logic        bus_rdy,
   output logic        irq
);

   logic             reg_we_s;
   logic             reg_re_s;
   logic [1:0]       reg_off_s;
   logic [31:0]      reg_wdata_s;

   ctrl_t            ctrl_r;
   logic             intr_r;
   logic [CNT_W-1:0] expr_r;
   logic [CNT_W-1:0] cnt_r;

   logic             expire_s;
   logic             wr_ctrl_s;
   logic             wr_intr_s;
   logic             wr_expr_s;
   logic             wr_cnt_s;
   logic [31:0]      rd_data_s;
   logic             unused_bits_s;

   // Only the word offset is decoded; upper address bits and write-data
   // bits beyond the counter width carry no meaning for this slave.
   assign unused_bits_s = ^{bus_addr[29:2], reg_wdata_s};

   bus_slave_ctrl #(
      .WAIT_CYC (WAIT_CYC)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .cs          (cs),
      .bus_as      (bus_as),
      .bus_rw      (bus_rw),
      .bus_off     (bus_addr[1:0]),
      .bus_wr_data (bus_wr_data),
      .bus_rdy     (bus_rdy),
      .reg_we      (reg_we_s),
      .reg_re      (reg_re_s),
      .reg_off     (reg_off_s),
      .reg_wdata   (reg_wdata_s)
   );

   assign expire_s  = ctrl_r.start && (cnt_r == expr_r);
   assign wr_ctrl_s = reg_we_s && (reg_off_s == OFF_CTRL);
   assign wr_intr_s = reg_we_s && (reg_off_s == OFF_INTR);
   assign wr_expr_s = reg_we_s && (reg_off_s == OFF_EXPR);
   assign wr_cnt_s  = reg_we_s && (reg_off_s == OFF_COUNTER);

   // CTRL: a bus write wins over the expiry-driven start update
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_r <= '0;
      end else if (wr_ctrl_s) begin
         ctrl_r.start    <= reg_wdata_s[CTRL_START_BIT];
         ctrl_r.periodic <= reg_wdata_s[CTRL_PERIODIC_BIT];
      end else if (expire_s) begin
         ctrl_r.start    <= ctrl_r.periodic;
         ctrl_r.periodic <= ctrl_r.periodic;
      end else begin
         ctrl_r <= ctrl_r;
      end
   end

   // INTR: expiry set beats a simultaneous bus clear so no interrupt is lost
   always_ff @(posedge clk) begin
      if (rst) begin
         intr_r <= 1'b0;
      end else if (expire_s) begin
         intr_r <= 1'b1;
      end else if (wr_intr_s) begin
         intr_r <= reg_wdata_s[0];
      end else begin
         intr_r <= intr_r;
      end
   end

   // EXPR: written only from the bus
   always_ff @(posedge clk) begin
      if (rst) begin
         expr_r <= '0;
      end else if (wr_expr_s) begin
         expr_r <= reg_wdata_s[CNT_W-1:0];
      end else begin
         expr_r <= expr_r;
      end
   end

   // COUNTER: bus write wins; otherwise count/wrap while started, else hold
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (wr_cnt_s) begin
         cnt_r <= reg_wdata_s[CNT_W-1:0];
      end else if (expire_s) begin
         cnt_r <= '0;
      end else if (ctrl_r.start) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Read mux: drives data only during the ready cycle of a read, else 0
   always_comb begin
      rd_data_s = 32'd0;
      if (reg_re_s) begin
         case (reg_off_s)
            OFF_CTRL:    rd_data_s = {30'd0, ctrl_r.periodic, ctrl_r.start};
            OFF_INTR:    rd_data_s = {31'd0, intr_r};
            OFF_EXPR:    rd_data_s = 32'(expr_r);
            OFF_COUNTER: rd_data_s = 32'(cnt_r);
            default:     rd_data_s = 32'd0;
         endcase
      end else begin
         rd_data_s = 32'd0;
      end
   end

   assign bus_rd_data = rd_data_s;
   assign irq         = intr_r;

endmodule

// File: doc/bus_slave_timer.md
Name: bus_slave_timer

Overview:
- Bus responder (slave end) for the req/grnt/as/rdy system bus whose master side is the IF/MEM bus interfaces.
- Decodes one-cycle address strobes from the granted master, inserts programmable wait states and returns a one-cycle ready with read data.
- Behind the bus port sits a 4-register interval timer: control, interrupt, expiry and counter registers.
- Drives a level interrupt toward the CPU interrupt controller; the slave is selected by the bus address decoder through cs.

Parameters:
- WAIT_CYC, 1, wait-state cycles between strobe capture and ready (0..15).
- CNT_W, 32, counter/expiry width (1..32; read data zero-extended).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- cs  in  1  slave select from bus address decoder (addr[29:27] match).
- bus_as  in  1  address strobe, one-cycle pulse from granted master.
- bus_rw  in  1  0 = read, 1 = write; held by master until rdy.
- bus_addr  in  30  word address; only [1:0] decoded; held until rdy.
- bus_wr_data  in  32  write data; held until rdy.
- bus_rd_data  out  32  read data; valid only while bus_rdy = 1, else 0.
- bus_rdy  out  1  ready, one-cycle pulse ending the access.
- irq  out  1  timer interrupt, equals INTR[0].

Behaviour:
- One clock; reset is synchronous and active-high on rst.
- Reset values: bus_rdy = 0, bus_rd_data = 0, irq = 0, CTRL = 0, INTR = 0, EXPR = 0, COUNTER = 0, FSM = IDLE.
- Register map, by addr[1:0]:
  - 0 CTRL: bit0 start, bit1 periodic; other bits read 0.
  - 1 INTR: bit0 irq.
  - 2 EXPR: expiry value.
  - 3 COUNTER: current count.
- FSM IDLE:
  - If cs & bus_as, latch rw, addr[1:0] and wr_data.
  - Go to WAIT, or straight to READY when WAIT_CYC = 0.
  - bus_as without cs is ignored.
- FSM WAIT:
  - A down-counter loaded with WAIT_CYC-1 at capture.
  - Go to READY when it reaches 0.
  - Strobes arriving in WAIT are ignored; there is no queueing.
- FSM READY:
  - bus_rdy = 1 for exactly this cycle.
  - For a read, bus_rd_data = the register value sampled this cycle.
  - For a write, the register is updated at the end of this cycle.
  - Next state is always IDLE; strobes in READY are ignored.
- Latency: strobe in cycle T gives rdy in cycle T+1+WAIT_CYC. Back-to-back accesses are spaced at least WAIT_CYC+2 cycles apart.
- bus_rd_data is combinational from the READY state and the latched offset, and is 0 outside READY.
- Timer, when CTRL.start = 1:
  - Each cycle, if COUNTER == EXPR then INTR[0] <= 1 and COUNTER <= 0, and CTRL.start <= CTRL.periodic. Otherwise COUNTER <= COUNTER+1.
  - Arithmetic is modulo 2^CNT_W.
  - EXPR = 0 with start set gives an expiry every cycle.
- Simultaneous events:
  - A bus write to CTRL or COUNTER in the same cycle as expiry: the bus write wins for the written register.
  - A bus write of 0 to INTR in the same cycle as expiry: the expiry set wins, so no interrupt is lost.
  - Writing 1 to INTR[0] sets irq.
- Reset mid-access (any FSM state): return to IDLE, no rdy is produced, and a pending write is discarded.
- The counter does not run while start = 0; COUNTER holds its value.

Decomposition:
- Shared package holds:
  - register offsets (CTRL=0, INTR=1, EXPR=2, COUNTER=3);
  - CTRL bit positions;
  - FSM state encodings (IDLE, WAIT, READY).
- Natural sub-module: bus_slave_ctrl. It contains the IDLE/WAIT/READY FSM, the capture latches and the rdy generation, exposes a one-cycle reg_we/reg_re strobe plus offset, and is reusable by other slaves (UART, GPIO).
- Timer datapath and register file stay in bus_slave_timer.

Test Plan:
1. WAIT_CYC=1: write EXPR=5 (as in cycle 0, cs=1) -> rdy high in cycle 2 only; a subsequent read of offset 2 returns 0x00000005, bus_rd_data = 0 outside the rdy cycle.
2. EXPR=3, write CTRL=0x1 (one-shot) -> COUNTER reads 0,1,2,3, then irq = 1 and start clears. COUNTER holds 0, irq stays 1 until INTR is written 0.
3. EXPR=2, CTRL=0x3 (periodic) -> expiry every 3 cycles. Clear INTR in the exact expiry cycle -> irq remains 1.
4. bus_as with cs=0, and a second bus_as during WAIT -> no rdy and no register change; only the first access completes.
5. WAIT_CYC=0 -> rdy in cycle T+1. WAIT_CYC=3 -> rdy in cycle T+4, single-cycle pulse.
6. rst asserted during WAIT of a write to COUNTER -> no rdy, COUNTER = 0, irq = 0, next access is served normally.
